pipe_hazard_ctrl: RTL and testbench

//   Drives the CE/flush side of the pipeline registers: decides each cycle whether
//   PC, IF/ID and ID/EX latch, hold or take a bubble. A per-register scoreboard

---
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW scoreboard, multiplier occupancy FSM and branch
// flush steering for the PC, IF/ID and ID/EX stage registers.
module pipe_hazard_ctrl #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wr,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_is_mul,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic             ex_br_taken,
  output logic             pc_ce,
  output logic             ifid_ce,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [NREG-1:0]  busy_vec,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MCW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } mul_state_e;

  mul_state_e       state_q, state_d;
  logic [MCW-1:0]   mul_cnt_q, mul_cnt_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [NREG-1:0]  clr_vec;
  logic [NREG-1:0]  set_vec;
  logic             raw_rs, raw_rt, raw, str, mul_blocks, stall, issue;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    for (int i = 1; i < NREG; i++) begin
      clr_vec[i] = wb_valid && (wb_rd == AW'(i));
      set_vec[i] = issue && id_wr && (id_rd == AW'(i));
    end
  end

  // Writeback clears in the same cycle it happens (write-through regfile).
  assign raw_rs = id_rs_used && (id_rs != '0) && busy_q[id_rs] && !clr_vec[id_rs];
  assign raw_rt = id_rt_used && (id_rt != '0) && busy_q[id_rt] && !clr_vec[id_rt];
  assign raw    = id_valid && (raw_rs || raw_rt);

  // The last occupied cycle (count==1) accepts a new MUL, so it does not block.
  assign mul_blocks = (state_q == S_BUSY) && (mul_cnt_q != MCW'(1));
  assign str        = id_valid && id_is_mul && mul_blocks;

  assign stall = (raw || str) && !ex_br_taken;
  assign issue = id_valid && !stall && !ex_br_taken;

  assign pc_ce       = !stall;
  assign ifid_ce     = !stall;
  assign ifid_flush  = ex_br_taken;
  assign idex_bubble = stall || ex_br_taken;
  assign busy_vec    = busy_q;
  assign mul_busy    = (state_q == S_BUSY);
  assign stall_cnt   = stall_cnt_q;

  // Set beats clear when issue and writeback target the same register.
  assign busy_d = set_vec | (busy_q & ~clr_vec);

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue && id_is_mul) begin
          state_d   = S_BUSY;
          mul_cnt_d = MCW'(MUL_LAT - 1);
        end
      end
      S_BUSY: begin
        if (mul_cnt_q == MCW'(1)) begin
          if (issue && id_is_mul) begin
            mul_cnt_d = MCW'(MUL_LAT - 1);
          end else begin
            state_d   = S_IDLE;
            mul_cnt_d = '0;
          end
        end else begin
          mul_cnt_d = mul_cnt_q - MCW'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        mul_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mul_cnt_q   <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, randomized run
// against a cycle-count based reference model, and counter saturation / async reset.
module tb_pipe_hazard_ctrl;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_rs_used, id_rt_used, id_wr, id_is_mul;
  logic [AW-1:0]    id_rs, id_rt, id_rd, wb_rd;
  logic             wb_valid, ex_br_taken;
  logic             pc_ce, ifid_ce, ifid_flush, idex_bubble, mul_busy;
  logic [NREG-1:0]  busy_vec;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_hazard_ctrl #(.NREG(NREG), .AW(AW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wr(id_wr), .id_rd(id_rd), .id_is_mul(id_is_mul),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .ex_br_taken(ex_br_taken),
    .pc_ce(pc_ce), .ifid_ce(ifid_ce), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .busy_vec(busy_vec), .mul_busy(mul_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [AW-1:0] rs;
    logic          rsu;
    logic [AW-1:0] rt;
    logic          rtu;
    logic          wr;
    logic [AW-1:0] rd;
    logic          mul;
    logic          wbv;
    logic [AW-1:0] wbrd;
    logic          br;
  } in_t;

  typedef struct {
    in_t             in;
    logic            pc;
    logic            flush;
    logic            bubble;
    logic [NREG-1:0] busy;
    logic            mb;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t x);
    id_valid = x.v;   id_rs = x.rs; id_rs_used = x.rsu; id_rt = x.rt; id_rt_used = x.rtu;
    id_wr = x.wr;     id_rd = x.rd; id_is_mul = x.mul;
    wb_valid = x.wbv; wb_rd = x.wbrd; ex_br_taken = x.br;
  endtask

  function automatic in_t mk(logic v, int rs, logic rsu, int rt, logic rtu, logic wr, int rd,
                             logic mul, logic wbv, int wbrd, logic br);
    in_t x;
    x.v = v; x.rs = AW'(rs); x.rsu = rsu; x.rt = AW'(rt); x.rtu = rtu; x.wr = wr;
    x.rd = AW'(rd); x.mul = mul; x.wbv = wbv; x.wbrd = AW'(wbrd); x.br = br;
    return x;
  endfunction

  function automatic vec_t row(in_t x, logic pc, logic fl, logic bub, logic [NREG-1:0] busy,
                               logic mb);
    vec_t r;
    r.in = x; r.pc = pc; r.flush = fl; r.bubble = bub; r.busy = busy; r.mb = mb;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference model: scoreboard as a plain pending-write array, multiplier as the
  // cycle number of the last MUL issue.
  bit          m_busy [NREG];
  longint      m_cyc;
  longint      m_last_mul;
  longint      m_stalls;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_cyc = 0; m_last_mul = -1000; m_stalls = 0;
  endtask

  task automatic model_step();
    bit     rs_h, rt_h, raw, str, stall, issue, occ;
    logic [NREG-1:0] exp_busy;
    longint sat;
    rs_h = id_rs_used && id_rs != 0 && m_busy[id_rs] && !(wb_valid && wb_rd == id_rs);
    rt_h = id_rt_used && id_rt != 0 && m_busy[id_rt] && !(wb_valid && wb_rd == id_rt);
    raw  = id_valid && (rs_h || rt_h);
    occ  = (m_cyc > m_last_mul) && (m_cyc <= m_last_mul + MUL_LAT - 1);
    str  = id_valid && id_is_mul && (m_cyc > m_last_mul) && (m_cyc < m_last_mul + MUL_LAT - 1);
    stall = (raw || str) && !ex_br_taken;
    issue = id_valid && !stall && !ex_br_taken;
    for (int i = 0; i < NREG; i++) exp_busy[i] = m_busy[i];
    sat = (m_stalls > (2 ** CNT_W) - 1) ? (2 ** CNT_W) - 1 : m_stalls;
    #3;
    check("pc_ce",       pc_ce,       !stall);
    check("ifid_ce",     ifid_ce,     !stall);
    check("ifid_flush",  ifid_flush,  ex_br_taken);
    check("idex_bubble", idex_bubble, stall || ex_br_taken);
    check("busy_vec",    busy_vec,    exp_busy);
    check("mul_busy",    mul_busy,    occ);
    check("stall_cnt",   stall_cnt,   sat);
    if (wb_valid) m_busy[wb_rd] = 1'b0;
    if (issue && id_wr && id_rd != 0) m_busy[id_rd] = 1'b1;
    if (issue && id_is_mul) m_last_mul = m_cyc;
    if (stall) m_stalls++;
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [17];

  initial begin
    // Directed table: RAW stall and release, r0, same-cycle set/clear, branch squash, MUL.
    tbl[0]  = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, '0, 0);
    tbl[1]  = row(mk(1, 1, 1, 2, 0, 1, 5, 0, 0, 0, 0), 1, 0, 0, '0, 0);
    tbl[2]  = row(mk(1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 0), 0, 0, 1, 32'h20, 0);
    tbl[3]  = row(mk(1, 5, 1, 0, 0, 1, 6, 0, 0, 0, 0), 0, 0, 1, 32'h20, 0);
    tbl[4]  = row(mk(1, 5, 1, 0, 0, 1, 6, 0, 1, 5, 0), 1, 0, 0, 32'h20, 0);
    tbl[5]  = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 32'h40, 0);
    tbl[6]  = row(mk(1, 0, 1, 6, 1, 1, 0, 0, 1, 6, 0), 1, 0, 0, 32'h40, 0);
    tbl[7]  = row(mk(1, 0, 1, 0, 1, 1, 7, 0, 1, 7, 0), 1, 0, 0, '0, 0);
    tbl[8]  = row(mk(1, 7, 1, 0, 0, 1, 9, 0, 0, 0, 1), 1, 1, 1, 32'h80, 0);
    tbl[9]  = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 32'h80, 0);
    tbl[10] = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0), 1, 0, 0, 32'h80, 0);
    tbl[11] = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, 0, 0, '0, 0);
    tbl[12] = row(mk(1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0), 1, 0, 0, '0, 0);
    tbl[13] = row(mk(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, 0), 0, 0, 1, 32'h400, 1);
    tbl[14] = row(mk(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, 0), 0, 0, 1, 32'h400, 1);
    tbl[15] = row(mk(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, 0), 1, 0, 0, 32'h400, 1);
    tbl[16] = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 32'hC00, 1);

    do_reset();
    @(posedge clk); #1;
    check("reset stall_cnt", stall_cnt, 0);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].in);
      #3;
      check($sformatf("tbl%0d pc_ce", i),       pc_ce,       tbl[i].pc);
      check($sformatf("tbl%0d ifid_ce", i),     ifid_ce,     tbl[i].pc);
      check($sformatf("tbl%0d ifid_flush", i),  ifid_flush,  tbl[i].flush);
      check($sformatf("tbl%0d idex_bubble", i), idex_bubble, tbl[i].bubble);
      check($sformatf("tbl%0d busy_vec", i),    busy_vec,    tbl[i].busy);
      check($sformatf("tbl%0d mul_busy", i),    mul_busy,    tbl[i].mb);
      @(posedge clk); #1;
    end
    check("tbl stall_cnt", stall_cnt, 4);

    // Randomized traffic over a small register window to provoke hazards.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      id_valid    = ($urandom_range(0, 9) < 8);
      id_rs       = AW'($urandom_range(0, 7));
      id_rt       = AW'($urandom_range(0, 7));
      id_rs_used  = $urandom_range(0, 1);
      id_rt_used  = $urandom_range(0, 1);
      id_wr       = ($urandom_range(0, 3) != 0);
      id_rd       = AW'($urandom_range(0, 7));
      id_is_mul   = ($urandom_range(0, 9) < 3);
      wb_valid    = $urandom_range(0, 1);
      wb_rd       = AW'($urandom_range(0, 7));
      ex_br_taken = ($urandom_range(0, 9) == 0);
      model_step();
    end

    // Long forced RAW stall: counter must saturate, then async reset mid-cycle.
    do_reset();
    drive(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat ((2 ** CNT_W) + 3) @(posedge clk);
    #1;
    check("sat stall_cnt", stall_cnt, (2 ** CNT_W) - 1);
    check("sat pc_ce", pc_ce, 0);
    check("sat busy5", busy_vec, 32'h20);
    #2 rst = 1'b1;
    #1;
    check("async rst stall_cnt", stall_cnt, 0);
    check("async rst busy_vec", busy_vec, 0);
    check("async rst mul_busy", mul_busy, 0);
    check("async rst pc_ce", pc_ce, 1);
    check("async rst idex_bubble", idex_bubble, 0);
    check("async rst ifid_flush", ifid_flush, 0);
    @(posedge clk); #1 rst = 1'b0;
    #3;
    check("post rst pc_ce", pc_ce, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
